// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : RV64 writeback stage. Holds the MEM/WB register, extracts load
//            data and shares the register-file write port with one
//            long-latency unit through a one-entry buffer.
// Option   : WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_mem,
    input  logic            stall_mem,
    input  logic            flush_mem,
    input  logic            regwrite_mem,
    input  logic            memtoreg_mem,
    input  logic [4:0]      dst_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [2:0]      addr_lo_mem,
    input  logic [XLEN-1:0] alu_res_mem,
    input  logic [XLEN-1:0] rdata_mem,
    input  logic            ll_valid,
    input  logic [4:0]      ll_dst,
    input  logic [XLEN-1:0] ll_data,
    output logic            ll_ready,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     retire_cnt,
`endif
    output logic            wb_stall_req,
    output logic            regwrite_wb,
    output logic [4:0]      dst_wb,
    output logic [XLEN-1:0] regwd_wb
);

    localparam int CW = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic            regwrite_q, regwrite_d;
    logic [4:0]      dst_q, dst_d;
    logic [XLEN-1:0] regwd_q, regwd_d;
    logic            buf_valid_q, buf_valid_d;
    logic [4:0]      buf_dst_q, buf_dst_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;

    logic            pipe_wr;
    logic            drain;
    logic            ll_accept;
    logic [XLEN-1:0] byte_sh, half_sh, word_sh;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] pipe_data;

    // A held or squashed instruction must never write, so stall and flush both gate.
    assign pipe_wr   = valid_mem & regwrite_mem & (dst_mem != 5'd0) & ~stall_mem & ~flush_mem;
    assign drain     = buf_valid_q & ~pipe_wr;
    assign ll_ready  = ~buf_valid_q | ~pipe_wr;
    assign ll_accept = ll_valid & ll_ready;

    assign byte_sh = rdata_mem >> {addr_lo_mem, 3'b000};
    assign half_sh = rdata_mem >> {addr_lo_mem[2:1], 4'b0000};
    assign word_sh = rdata_mem >> {addr_lo_mem[2], 5'b00000};

    always_comb begin
        load_val = rdata_mem;
        case (funct3_mem)
            3'b000:  load_val = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  load_val = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            3'b010:  load_val = {{(XLEN-32){word_sh[31]}}, word_sh[31:0]};
            3'b011:  load_val = rdata_mem;
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            3'b110:  load_val = {{(XLEN-32){1'b0}}, word_sh[31:0]};
            default: load_val = rdata_mem;
        endcase
    end

    assign pipe_data = memtoreg_mem ? load_val : alu_res_mem;

    always_comb begin
        regwrite_d  = 1'b0;
        dst_d       = dst_q;
        regwd_d     = regwd_q;
        buf_valid_d = buf_valid_q;
        buf_dst_d   = buf_dst_q;
        buf_data_d  = buf_data_q;
        starve_d    = starve_q;
        stall_d     = stall_q;

        if (pipe_wr) begin
            regwrite_d = 1'b1;
            dst_d      = dst_mem;
            regwd_d    = pipe_data;
        end else if (buf_valid_q) begin
            regwrite_d  = 1'b1;
            dst_d       = buf_dst_q;
            regwd_d     = buf_data_q;
            buf_valid_d = 1'b0;
        end

        // Accept implies the buffer is empty or draining now, so refill is safe.
        if (ll_accept) begin
            buf_valid_d = (ll_dst != 5'd0);
            if (ll_dst != 5'd0) begin
                buf_dst_d  = ll_dst;
                buf_data_d = ll_data;
            end
        end

        if (drain || !buf_valid_q) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        if (drain) begin
            stall_d = 1'b0;
        end else if (buf_valid_q && (starve_d == STARVE_LIM)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regwrite_q  <= 1'b0;
            dst_q       <= 5'd0;
            regwd_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_dst_q   <= 5'd0;
            buf_data_q  <= '0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            dst_q       <= dst_d;
            regwd_q     <= regwd_d;
            buf_valid_q <= buf_valid_d;
            buf_dst_q   <= buf_dst_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
        end
    end

    assign regwrite_wb  = regwrite_q;
    assign dst_wb       = dst_q;
    assign regwd_wb     = regwd_q;
    assign wb_stall_req = stall_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q, retire_d;

    // Counts every instruction leaving MEM, writing or not; ll results excluded.
    assign retire_d = (valid_mem & ~stall_mem & ~flush_mem) ? retire_q + 64'd1 : retire_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_q <= 64'd0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Scoreboard bench for wb_stage; expected writes are queued by the
//            stimulus and popped by a negedge monitor on every regwrite_wb.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_mem, stall_mem, flush_mem, regwrite_mem, memtoreg_mem;
    logic [4:0]  dst_mem;
    logic [2:0]  funct3_mem, addr_lo_mem;
    logic [63:0] alu_res_mem, rdata_mem;
    logic        ll_valid;
    logic [4:0]  ll_dst;
    logic [63:0] ll_data;
    logic        ll_ready, wb_stall_req, regwrite_wb;
    logic [4:0]  dst_wb;
    logic [63:0] regwd_wb;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [68:0] exp_q[$];

    always #5 clk = ~clk;

    wb_stage #(.XLEN(64), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .valid_mem    (valid_mem),
        .stall_mem    (stall_mem),
        .flush_mem    (flush_mem),
        .regwrite_mem (regwrite_mem),
        .memtoreg_mem (memtoreg_mem),
        .dst_mem      (dst_mem),
        .funct3_mem   (funct3_mem),
        .addr_lo_mem  (addr_lo_mem),
        .alu_res_mem  (alu_res_mem),
        .rdata_mem    (rdata_mem),
        .ll_valid     (ll_valid),
        .ll_dst       (ll_dst),
        .ll_data      (ll_data),
        .ll_ready     (ll_ready),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt   (retire_cnt),
`endif
        .wb_stall_req (wb_stall_req),
        .regwrite_wb  (regwrite_wb),
        .dst_wb       (dst_wb),
        .regwd_wb     (regwd_wb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_mem = 0; stall_mem = 0; flush_mem = 0; regwrite_mem = 0; memtoreg_mem = 0;
        dst_mem = 0; funct3_mem = 0; addr_lo_mem = 0; alu_res_mem = 0;
        ll_valid = 0; ll_dst = 0; ll_data = 0;
    endtask

    task automatic pipe(input logic [4:0] d, input logic mtr, input logic [2:0] f3,
                        input logic [2:0] a, input logic [63:0] alu);
        valid_mem = 1; regwrite_mem = 1; stall_mem = 0; flush_mem = 0;
        dst_mem = d; memtoreg_mem = mtr; funct3_mem = f3; addr_lo_mem = a; alu_res_mem = alu;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [63:0] v);
        exp_q.push_back({d, v});
    endtask

    // Monitor: every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (regwrite_wb === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got x%0d=0x%016h expected no write", dst_wb, regwd_wb);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                if ({dst_wb, regwd_wb} !== e) begin
                    n_errors++;
                    $display("FAIL write: got x%0d=0x%016h expected x%0d=0x%016h",
                             dst_wb, regwd_wb, e[68:64], e[63:0]);
                end
            end
        end
    end

    initial begin
        idle();
        rdata_mem = 64'h8877_6655_4433_2211;
        rstn = 0;
        repeat (2) tick();
        check("reset_regwrite", {63'd0, regwrite_wb}, 64'd0);
        check("reset_dst", {59'd0, dst_wb}, 64'd0);
        check("reset_regwd", regwd_wb, 64'd0);
        check("reset_stall_req", {63'd0, wb_stall_req}, 64'd0);
        check("reset_ll_ready", {63'd0, ll_ready}, 64'd1);
        rstn = 1;
        tick();

        // Load extraction and ALU select
        pipe(5'd1, 1, 3'b000, 3'd7, 64'h0); expect_wr(5'd1, 64'hFFFF_FFFF_FFFF_FF88); tick();
        pipe(5'd2, 1, 3'b101, 3'd6, 64'h0); expect_wr(5'd2, 64'h0000_0000_0000_8877); tick();
        pipe(5'd3, 1, 3'b010, 3'd4, 64'h0); expect_wr(5'd3, 64'hFFFF_FFFF_8877_6655); tick();
        pipe(5'd4, 1, 3'b011, 3'd0, 64'h0); expect_wr(5'd4, 64'h8877_6655_4433_2211); tick();
        pipe(5'd5, 1, 3'b100, 3'd0, 64'h0); expect_wr(5'd5, 64'h0000_0000_0000_0011); tick();
        pipe(5'd6, 1, 3'b001, 3'd2, 64'h0); expect_wr(5'd6, 64'h0000_0000_0000_4433); tick();
        pipe(5'd7, 1, 3'b110, 3'd0, 64'h0); expect_wr(5'd7, 64'h0000_0000_4433_2211); tick();
        pipe(5'd8, 0, 3'b011, 3'd0, 64'h1234); expect_wr(5'd8, 64'h1234); tick();
        idle(); tick();

        // Pipe and long-latency in the same cycle
        pipe(5'd5, 0, 3'b011, 3'd0, 64'h10);
        ll_valid = 1; ll_dst = 5'd6; ll_data = 64'h20;
        #1 check("ll_ready_same_cycle", {63'd0, ll_ready}, 64'd1);
        expect_wr(5'd5, 64'h10); expect_wr(5'd6, 64'h20);
        tick();
        idle(); tick();
        check("ll_drain_write", {63'd0, regwrite_wb}, 64'd1);
        tick();

        // Stall for three cycles, then exactly one write
        pipe(5'd8, 0, 3'b011, 3'd0, 64'h88);
        stall_mem = 1;
        repeat (3) begin
            tick();
            check("stalled_no_write", {63'd0, regwrite_wb}, 64'd0);
        end
        stall_mem = 0; expect_wr(5'd8, 64'h88); tick();
        idle(); tick();
        check("single_write_after_stall", {63'd0, regwrite_wb}, 64'd0);
        pipe(5'd9, 0, 3'b011, 3'd0, 64'h99); flush_mem = 1; tick();
        pipe(5'd9, 0, 3'b011, 3'd0, 64'h99); flush_mem = 1; stall_mem = 1; tick();
        pipe(5'd0, 0, 3'b011, 3'd0, 64'h77); tick();
        idle(); tick();
        check("no_write_flush_x0", {63'd0, regwrite_wb}, 64'd0);

        // Starvation: buffer held while the pipe writes every cycle
        pipe(5'd11, 0, 3'b011, 3'd0, 64'h100);
        ll_valid = 1; ll_dst = 5'd10; ll_data = 64'hAA;
        expect_wr(5'd11, 64'h100);
        tick();
        ll_valid = 0; ll_dst = 0; ll_data = 0;
        for (int i = 1; i <= 4; i++) begin
            pipe(5'd11, 0, 3'b011, 3'd0, 64'h100 + 64'(i));
            #1 check("ll_ready_blocked", {63'd0, ll_ready}, 64'd0);
            expect_wr(5'd11, 64'h100 + 64'(i));
            tick();
            check($sformatf("stall_req_after_%0d", i), {63'd0, wb_stall_req}, (i == 4) ? 64'd1 : 64'd0);
        end
        stall_mem = 1;
        expect_wr(5'd10, 64'hAA);
        tick();
        check("stall_req_cleared", {63'd0, wb_stall_req}, 64'd0);
        check("ll_ready_after_drain", {63'd0, ll_ready}, 64'd1);
        idle(); tick();

        // Back-to-back long-latency results
        for (int i = 0; i < 3; i++) begin
            ll_valid = 1; ll_dst = 5'(12 + i); ll_data = 64'h300 + 64'(i);
            #1 check("b2b_ll_ready", {63'd0, ll_ready}, 64'd1);
            expect_wr(5'(12 + i), 64'h300 + 64'(i));
            tick();
            if (i > 0) check("b2b_consecutive", {63'd0, regwrite_wb}, 64'd1);
        end
        idle(); tick();
        check("b2b_last_write", {63'd0, regwrite_wb}, 64'd1);
        ll_valid = 1; ll_dst = 5'd0; ll_data = 64'hDEAD; tick();
        idle(); tick();
        check("ll_x0_discarded", {63'd0, regwrite_wb}, 64'd0);

        // Reset while a write is presented and the buffer is full
        pipe(5'd15, 0, 3'b011, 3'd0, 64'h150);
        ll_valid = 1; ll_dst = 5'd16; ll_data = 64'h160;
        expect_wr(5'd15, 64'h150);
        tick();
        check("pre_reset_write", {63'd0, regwrite_wb}, 64'd1);
        idle();
        @(negedge clk); #1;
        rstn = 0;
        #1;
        check("midrst_regwrite", {63'd0, regwrite_wb}, 64'd0);
        check("midrst_dst", {59'd0, dst_wb}, 64'd0);
        check("midrst_regwd", regwd_wb, 64'd0);
        check("midrst_ll_ready", {63'd0, ll_ready}, 64'd1);
        repeat (2) tick();
        rstn = 1;
        repeat (3) tick();
        check("post_reset_no_write", {63'd0, regwrite_wb}, 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
